memory_port_arbiter: RTL and testbench

- Shares one single-ported memory32 instance between two requesters: instruction fetch (i-port) and data load/store (d-port).
- Arbitrates per cycle and registers the winning request onto the memory port.
- Tracks the owner of every in-flight access and routes each memory response back to the port that issued it.
- Sits between the pipeline's fetch/MEM stages and the unified memory.

---
 rtl/memory_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory32 between the
// instruction-fetch port (i) and the data load/store port (d).
// A per-cycle arbiter picks one requester, the winning request is registered
// onto mreq, and an owner shift register routes each memory response back to
// the port that issued it.
// Optional build macro MEMARB_DATA_PRIORITY_EN: the d-port wins ties, with a
// starve counter that forces an i-port win after STARVE_LIMIT d-port wins.
// Without the macro, ties are broken round-robin using the last accepted port.
//
// Handshake: a request transfers in any cycle where valid && ready are both 1.
// ready depends on the valid inputs, so a requester must not make valid wait
// on ready, and it holds the request stable while valid=1 and ready=0.

package memory_io_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic [7:0]  user_tag;
  } memory_io_req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  user_tag;
  } memory_io_rsp32;
endpackage

module memory_port_arbiter
  import memory_io_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  memory_io_req32 ireq,
  output logic           ireq_ready,
  output memory_io_rsp32 irsp,
  input  memory_io_req32 dreq,
  output logic           dreq_ready,
  output memory_io_rsp32 drsp,
  output memory_io_req32 mreq,
  input  memory_io_rsp32 mrsp,
  output logic [CNT_W-1:0] grant_cnt_i,
  output logic [CNT_W-1:0] grant_cnt_d,
  output logic           err_orphan
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("memory_port_arbiter: MEM_LATENCY must be 1..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("memory_port_arbiter: STARVE_LIMIT must be 1..15");
  end

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  typedef struct packed {
    logic  exp_rsp;
    port_e port;
  } owner_t;

  logic   grant_i;
  logic   grant_d;
  owner_t new_owner;
  owner_t head;
  // Entry 0 holds the access currently on mreq; entry MEM_LATENCY is the
  // access whose response is on mrsp this cycle.
  owner_t [MEM_LATENCY:0] owner_q;

`ifdef MEMARB_DATA_PRIORITY_EN
  logic [3:0] starve_q;
`else
  port_e      last_q;
`endif

  // Per-cycle grant; nothing is granted while reset is asserted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset) begin
      if (ireq.valid && dreq.valid) begin
`ifdef MEMARB_DATA_PRIORITY_EN
        if (starve_q == 4'(STARVE_LIMIT)) grant_i = 1'b1;
        else                              grant_d = 1'b1;
`else
        if (last_q == PORT_D) grant_i = 1'b1;
        else                  grant_d = 1'b1;
`endif
      end else if (ireq.valid) begin
        grant_i = 1'b1;
      end else if (dreq.valid) begin
        grant_d = 1'b1;
      end
    end
  end

  assign ireq_ready = grant_i;
  assign dreq_ready = grant_d;

  // A request with both byte masks clear is forwarded but gets no response.
  assign new_owner.exp_rsp = grant_i ? ((|ireq.do_read) || (|ireq.do_write)) :
                             grant_d ? ((|dreq.do_read) || (|dreq.do_write)) : 1'b0;
  assign new_owner.port    = grant_d ? PORT_D : PORT_I;
  assign head              = owner_q[MEM_LATENCY];

  // Register the accepted request onto the memory port, unmodified.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mreq <= '0;
    else if (grant_i) mreq <= ireq;
    else if (grant_d) mreq <= dreq;
    else              mreq <= '0;
  end

  // Owner pipeline follows each access through the memory latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner_q <= '0;
    else        owner_q <= {owner_q[MEM_LATENCY-1:0], new_owner};
  end

  // Grant counters and tie-break state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt_i <= '0;
      grant_cnt_d <= '0;
`ifdef MEMARB_DATA_PRIORITY_EN
      starve_q    <= '0;
`else
      last_q      <= PORT_D;
`endif
    end else begin
      if (grant_i) grant_cnt_i <= grant_cnt_i + CNT_W'(1);
      if (grant_d) grant_cnt_d <= grant_cnt_d + CNT_W'(1);
`ifdef MEMARB_DATA_PRIORITY_EN
      if (grant_i || !ireq.valid) starve_q <= '0;
      else if (grant_d)           starve_q <= starve_q + 4'd1;
`else
      if (grant_i)      last_q <= PORT_I;
      else if (grant_d) last_q <= PORT_D;
`endif
    end
  end

  // Sticky flag: a response arrived that no in-flight access was waiting for.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          err_orphan <= 1'b0;
    else if (mrsp.valid && !head.exp_rsp) err_orphan <= 1'b1;
  end

  // Route the memory response to its owner in the cycle it arrives.
  always_comb begin
    irsp = '0;
    drsp = '0;
    if (reset && mrsp.valid && head.exp_rsp) begin
      if (head.port == PORT_I) irsp = mrsp;
      else                     drsp = mrsp;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a behavioural memory32 model, directed
// scenarios and a short random burst; responses are checked through a
// per-port expected queue.
module tb_memory_port_arbiter;
  import memory_io_pkg::*;

  localparam int LAT = 1;
  localparam int SL  = 4;
  localparam int CW  = 32;

`ifdef MEMARB_DATA_PRIORITY_EN
  localparam logic [9:0] ORDER_I = 10'b10_0001_0000; // 1 = i-port wins
  localparam int C4_I = 0, C4_D = 4, C10_I = 2, C10_D = 8;
`else
  localparam logic [9:0] ORDER_I = 10'b01_0101_0101;
  localparam int C4_I = 2, C4_D = 2, C10_I = 5, C10_D = 5;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memory_io_req32 ireq, dreq, mreq;
  memory_io_rsp32 irsp, drsp, mrsp;
  logic ireq_ready, dreq_ready, err_orphan;
  logic [CW-1:0] grant_cnt_i, grant_cnt_d;

  memory_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .ireq_ready(ireq_ready), .irsp(irsp),
    .dreq(dreq), .dreq_ready(dreq_ready), .drsp(drsp),
    .mreq(mreq), .mrsp(mrsp),
    .grant_cnt_i(grant_cnt_i), .grant_cnt_d(grant_cnt_d),
    .err_orphan(err_orphan)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 4)  return 32'hDEAD_BEEF;
    if (k < 16)  return 32'h0;
    return {16'hB0B0, 8'h00, 8'(k)};
  endfunction

  // ---------------- memory32 model ----------------
  logic [31:0]    mem [256];
  memory_io_rsp32 pipe [LAT];
  bit             mem_init_done = 1'b0;
  memory_io_rsp32 mr;

  always @(posedge clk) begin
    mr = '0;
    if (!mem_init_done) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
      mem_init_done <= 1'b1;
    end else if (mreq.valid && ((|mreq.do_read) || (|mreq.do_write))) begin
      mr.valid    = 1'b1;
      mr.user_tag = mreq.user_tag;
      mr.data     = mem[mreq.addr[9:2]];
      if (mreq.do_read == 4'h0)
        for (int b = 0; b < 4; b++)
          if (mreq.do_write[b]) mem[mreq.addr[9:2]][b*8 +: 8] <= mreq.data[b*8 +: 8];
    end
    pipe[0] <= mr;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mrsp = pipe[LAT-1];

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] ref_mem [256];
  logic [40:0] exp_i_q[$];   // {check_data, data, user_tag}
  logic [40:0] exp_d_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_req(input bit to_d, input memory_io_req32 r);
    logic [40:0] e;
    if (r.do_read != 4'h0) begin
      e = {1'b1, ref_mem[r.addr[9:2]], r.user_tag};
    end else if (r.do_write != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (r.do_write[b]) ref_mem[r.addr[9:2]][b*8 +: 8] = r.data[b*8 +: 8];
      e = {1'b0, 32'h0, r.user_tag};
    end else begin
      return;
    end
    if (to_d) exp_d_q.push_back(e);
    else      exp_i_q.push_back(e);
  endtask

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [40:0] e;
    if (irsp.valid) begin
      if (exp_i_q.size() == 0) check_eq("irsp_unexpected", 64'(irsp.user_tag), 64'hFFF);
      else begin
        e = exp_i_q.pop_front();
        check_eq("irsp_tag", 64'(irsp.user_tag), 64'(e[7:0]));
        if (e[40]) check_eq("irsp_data", 64'(irsp.data), 64'(e[39:8]));
      end
    end
    if (drsp.valid) begin
      if (exp_d_q.size() == 0) check_eq("drsp_unexpected", 64'(drsp.user_tag), 64'hFFF);
      else begin
        e = exp_d_q.pop_front();
        check_eq("drsp_tag", 64'(drsp.user_tag), 64'(e[7:0]));
        if (e[40]) check_eq("drsp_data", 64'(drsp.data), 64'(e[39:8]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic memory_io_req32 mk_req(input logic [31:0] addr, input logic [31:0] data,
                                            input logic [3:0] rd, input logic [3:0] wr,
                                            input logic [7:0] tag);
    memory_io_req32 r;
    r.valid = 1'b1; r.addr = addr; r.data = data;
    r.do_read = rd; r.do_write = wr; r.user_tag = tag;
    return r;
  endfunction

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle_req(input memory_io_req32 i, input memory_io_req32 d,
                           output logic ia, output logic da);
    ireq = i; dreq = d;
    #1;
    ia = i.valid && ireq_ready;
    da = d.valid && dreq_ready;
    if (ia) expect_req(1'b0, i);
    if (da) expect_req(1'b1, d);
    @(posedge clk);
    @(negedge clk);
    ireq = '0; dreq = '0;
  endtask

  task automatic do_reset();
    ireq = '0; dreq = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_i_q.delete(); exp_d_q.delete();
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_i_q.size() != 0 || exp_d_q.size() != 0) && n < 20) begin
      @(negedge clk); n++;
    end
    check_eq("drain_empty", 64'(exp_i_q.size() + exp_d_q.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ia, da;
    memory_io_req32 ci, cd;
    int ni, nd;
    bit pi, pd;
    logic [7:0] tag;
    logic [9:0] exp_order;

    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    ireq = mk_req(32'h10, 32'h0, 4'hF, 4'h0, 8'h01);
    dreq = mk_req(32'h20, 32'h0, 4'hF, 4'h0, 8'h02);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state with both requesters valid.
    check_eq("rst_ireq_ready", 64'(ireq_ready), 64'h0);
    check_eq("rst_dreq_ready", 64'(dreq_ready), 64'h0);
    check_eq("rst_mreq", 64'(mreq.valid), 64'h0);
    check_eq("rst_cnt_i", 64'(grant_cnt_i), 64'h0);
    check_eq("rst_cnt_d", 64'(grant_cnt_d), 64'h0);
    check_eq("rst_err", 64'(err_orphan), 64'h0);
    check_eq("rst_irsp", 64'(irsp), 64'h0);
    check_eq("rst_drsp", 64'(drsp), 64'h0);
    ireq = '0; dreq = '0;
    reset = 1'b1;
    @(negedge clk);

    // Single i-port read with latency checks.
    cycle_req(mk_req(32'h10, 32'h0, 4'hF, 4'h0, 8'h3C), '0, ia, da);
    check_eq("t1_ready", 64'(ia), 64'h1);
    check_eq("t1_mreq_valid", 64'(mreq.valid), 64'h1);
    check_eq("t1_mreq_addr", 64'(mreq.addr), 64'h10);
    check_eq("t1_irsp_early", 64'(irsp.valid), 64'h0);
    @(negedge clk);
    check_eq("t1_irsp_valid", 64'(irsp.valid), 64'h1);
    check_eq("t1_irsp_data", 64'(irsp.data), 64'hDEAD_BEEF);
    check_eq("t1_irsp_tag", 64'(irsp.user_tag), 64'h3C);
    check_eq("t1_drsp", 64'(drsp.valid), 64'h0);
    check_eq("t1_cnt_i", 64'(grant_cnt_i), 64'h1);
    check_eq("t1_cnt_d", 64'(grant_cnt_d), 64'h0);
    drain();

    // Both ports valid continuously from reset.
    do_reset();
    exp_order = ORDER_I;
    ni = 0; nd = 0;
    ci = mk_req(32'h40, 32'h0, 4'hF, 4'h0, 8'h10);
    cd = mk_req(32'h80, 32'h0, 4'hF, 4'h0, 8'h20);
    for (int c = 0; c < 10; c++) begin
      cycle_req(ci, cd, ia, da);
      check_eq("arb_grant_i", 64'(ia), 64'(exp_order[c]));
      check_eq("arb_grant_d", 64'(da), 64'(!exp_order[c]));
      if (ia) begin ni++; ci = mk_req(32'h40 + 32'(4*ni), 32'h0, 4'hF, 4'h0, 8'(8'h10 + ni)); end
      if (da) begin nd++; cd = mk_req(32'h80 + 32'(4*nd), 32'h0, 4'hF, 4'h0, 8'(8'h20 + nd)); end
      if (c == 3) begin
        check_eq("arb_cnt4_i", 64'(grant_cnt_i), 64'(C4_I));
        check_eq("arb_cnt4_d", 64'(grant_cnt_d), 64'(C4_D));
      end
    end
    check_eq("arb_cnt10_i", 64'(grant_cnt_i), 64'(C10_I));
    check_eq("arb_cnt10_d", 64'(grant_cnt_d), 64'(C10_D));
    drain();

    // Partial write from d-port, then i-port read of the same word.
    cycle_req('0, mk_req(32'h20, 32'h1234_5678, 4'h0, 4'b0011, 8'h21), ia, da);
    check_eq("t3_wr_ready", 64'(da), 64'h1);
    cycle_req(mk_req(32'h20, 32'h0, 4'hF, 4'h0, 8'h31), '0, ia, da);
    check_eq("t3_drsp_valid", 64'(drsp.valid), 64'h1);
    check_eq("t3_drsp_tag", 64'(drsp.user_tag), 64'h21);
    @(negedge clk);
    check_eq("t3_irsp_valid", 64'(irsp.valid), 64'h1);
    check_eq("t3_irsp_data", 64'(irsp.data), 64'h0000_5678);
    drain();

    // d-port request with no byte enables: forwarded, no response.
    cycle_req('0, mk_req(32'h30, 32'hFFFF_FFFF, 4'h0, 4'h0, 8'h41), ia, da);
    check_eq("t4_none_ready", 64'(da), 64'h1);
    check_eq("t4_none_fwd", 64'(mreq.valid), 64'h1);
    cycle_req(mk_req(32'h10, 32'h0, 4'hF, 4'h0, 8'h42), '0, ia, da);
    check_eq("t4_no_drsp", 64'(drsp.valid), 64'h0);
    @(negedge clk);
    check_eq("t4_irsp_data", 64'(irsp.data), 64'hDEAD_BEEF);
    check_eq("t4_no_drsp2", 64'(drsp.valid), 64'h0);
    check_eq("t4_err", 64'(err_orphan), 64'h0);
    drain();

    // Reset while an access is in flight; its response becomes an orphan.
    cycle_req(mk_req(32'h10, 32'h0, 4'hF, 4'h0, 8'h55), '0, ia, da);
    check_eq("t5_accept", 64'(ia), 64'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_i_q.delete();
    #1 check_eq("t5_irsp_in_reset", 64'(irsp), 64'h0);
    #1 reset = 1'b1;
    #1 check_eq("t5_irsp_after", 64'(irsp.valid), 64'h0);
    check_eq("t5_err_before", 64'(err_orphan), 64'h0);
    @(posedge clk);
    #1 check_eq("t5_err_set", 64'(err_orphan), 64'h1);
    @(negedge clk);
    cycle_req(mk_req(32'h10, 32'h0, 4'hF, 4'h0, 8'h66), '0, ia, da);
    check_eq("t5_next_accept", 64'(ia), 64'h1);
    @(negedge clk);
    check_eq("t5_next_irsp", 64'(irsp.data), 64'hDEAD_BEEF);
    check_eq("t5_next_tag", 64'(irsp.user_tag), 64'h66);
    check_eq("t5_cnt_i", 64'(grant_cnt_i), 64'h1);
    drain();

    // Random burst on both ports.
    pi = 1'b0; pd = 1'b0; tag = 8'h80;
    for (int c = 0; c < 40; c++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin
        ci = mk_req(32'h100 + 32'(4*$urandom_range(0, 31)), $urandom, 4'h0, 4'h0, tag++);
        case ($urandom_range(0, 4))
          0, 1: ci.do_read = 4'hF;
          2:    ci.do_write = 4'($urandom_range(1, 15));
          3:    ;
          default: begin ci.do_read = 4'hF; ci.do_write = 4'hF; end
        endcase
        pi = 1'b1;
      end
      if (!pd && $urandom_range(0, 3) != 0) begin
        cd = mk_req(32'h100 + 32'(4*$urandom_range(0, 31)), $urandom, 4'h0, 4'h0, tag++);
        case ($urandom_range(0, 4))
          0, 1: cd.do_read = 4'hF;
          2:    cd.do_write = 4'($urandom_range(1, 15));
          3:    ;
          default: begin cd.do_read = 4'hF; cd.do_write = 4'hF; end
        endcase
        pd = 1'b1;
      end
      cycle_req(pi ? ci : '0, pd ? cd : '0, ia, da);
      if (pi || pd) check_eq("rand_one_grant", 64'(ia ^ da), 64'h1);
      if (ia) pi = 1'b0;
      if (da) pd = 1'b0;
    end
    drain();
    check_eq("err_sticky", 64'(err_orphan), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
